// File: rtl/ram_8x8.sv
// ----------------------------------------------------------------------------
// ram_8x8 -- small register-file RAM with a registered read port.
//
// DEPTH words of WIDTH bits, each held in its own register and selected by a
// one-hot address decoder. One operation per clock edge, qualified by en:
// w=1 writes D into word[addr]; w=0 loads out with word[addr] on that edge.
// A write never disturbs out. With en=0 nothing changes. An asynchronous
// active-low reset clears every word and out.
//
// Ports
//   clk    in   1                 rising-edge clock
//   rst_n  in   1                 asynchronous active-low reset
//   D      in   WIDTH             write data
//   w      in   1                 1 = write, 0 = read (when en=1)
//   addr   in   log2(DEPTH)       word address
//   en     in   1                 operation enable
//   out    out  WIDTH             registered read data
// ----------------------------------------------------------------------------
module ram_8x8 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D,
   input  logic             w,
   input  logic [AW-1:0]    addr,
   input  logic             en,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] word_q [DEPTH];
   logic [DEPTH-1:0] sel;
   logic [DEPTH-1:0] wr_sel;
   logic [WIDTH-1:0] rd_data;

   // One-hot decode of addr. Only codes 0..DEPTH-1 raise a select line, so
   // an out-of-range address (possible only for non-power-of-two DEPTH)
   // selects nothing: a write is dropped and a read returns 0.
   always_comb begin
      // NOTE: every combinational output gets a default before any
      // conditional assignment; otherwise a latch is inferred.
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == AW'(i)) begin
            sel[i] = 1'b1;
         end
      end
   end

   assign wr_sel = sel & {DEPTH{en & w}};

   // AND-OR read mux driven by the same one-hot select.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel[i]) begin
            rd_data = rd_data | word_q[i];
         end
      end
   end

   // Word storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is a register file, not a RAM macro, so it is
         // legal and required to clear every word in reset; a macro-backed
         // memory could not be reset this way.
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               // NOTE: sequential state uses non-blocking assignments so all
               // registers update together from pre-edge values.
               word_q[i] <= D;
            end
         end
      end
   end

   // Read register: loads only on an enabled read, so writes and idle
   // cycles leave the last read value on out. Because the decode and mux are
   // combinational off the current word registers, a read the cycle after a
   // write sees the freshly written word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else if (en && !w) begin
         out <= rd_data;
      end
   end

endmodule

// File: tb/tb_ram_8x8.sv
// ----------------------------------------------------------------------------
// tb_ram_8x8 -- scoreboard bench for ram_8x8.
//
// The stimulus process drives one operation per clock (inputs change on the
// falling edge) and updates a plain array model of the memory. Every read
// pushes the model's word into exp_q. The monitor process watches each rising
// edge: after an enabled read it pops and compares out on the next falling
// edge; after any other cycle it checks that out held its previous value.
// ----------------------------------------------------------------------------
module tb_ram_8x8;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] D = '0;
   logic             w = 1'b0;
   logic [AW-1:0]    addr = '0;
   logic             en = 1'b0;
   logic [WIDTH-1:0] out;

   ram_8x8 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .D    (D),
      .w    (w),
      .addr (addr),
      .en   (en),
      .out  (out)
   );

   always #5 clk = ~clk;

   // Reference model and scoreboard.
   logic [WIDTH-1:0] mem_model [DEPTH];
   logic [WIDTH-1:0] model_out = '0;
   logic [WIDTH-1:0] exp_q [$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
      model_out = '0;
   endtask

   // One operation presented for the next rising edge.
   task automatic op(input logic e, input logic wr, input int a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      en   = e;
      w    = wr;
      addr = AW'(a);
      D    = d;
      if (e && wr) mem_model[a] = d;
      if (e && !wr) exp_q.push_back(mem_model[a]);
   endtask

   task automatic wr_op(input int a, input logic [WIDTH-1:0] d);
      op(1'b1, 1'b1, a, d);
   endtask

   task automatic rd_op(input int a);
      op(1'b1, 1'b0, a, 8'h00);
   endtask

   task automatic idle();
      op(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
   endtask

   // Reset pulse entirely between two clock edges.
   task automatic reset_pulse();
      @(negedge clk);
      en = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("reset_out_async", 32'(out), 32'h0);
      clear_model();
      #1 rst_n = 1'b1;
   endtask

   // Monitor.
   initial begin
      logic rd;
      logic [WIDTH-1:0] e;
      forever begin
         @(posedge clk);
         rd = en && !w && rst_n;
         @(negedge clk);
         if (rd) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_unexpected: got 0x%0h expected no read at %0t", out, $time);
            end else begin
               e = exp_q.pop_front();
               check("read", 32'(out), 32'(e));
               model_out = e;
            end
         end else begin
            check("hold", 32'(out), 32'(model_out));
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin
      clear_model();
      // Power-up: reset held across edges with a pending write that must
      // be ignored.
      en = 1'b1; w = 1'b1; addr = 3'd3; D = 8'hFF;
      #1 check("reset_out_initial", 32'(out), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      #2 rst_n = 1'b1;

      for (int a = 0; a < DEPTH; a++) rd_op(a);

      // Basic write/read.
      wr_op(1, 8'h01);
      idle();
      wr_op(4, 8'h0B);
      rd_op(1);
      rd_op(4);
      repeat (3) idle();

      // Gating: disabled write leaves memory alone; a write leaves out alone.
      op(1'b0, 1'b1, 2, 8'hFF);
      rd_op(2);
      wr_op(6, 8'h77);
      idle();

      // Full sweep, then overwrite addr 7.
      for (int a = 0; a < DEPTH; a++) wr_op(a, 8'hA0 + 8'(a));
      for (int a = 0; a < DEPTH; a++) rd_op(a);
      wr_op(7, 8'h5A);
      for (int a = 0; a < DEPTH; a++) rd_op(a);

      // Back-to-back write then read of the same word.
      wr_op(5, 8'h3C);
      rd_op(5);

      // Reset mid-run.
      reset_pulse();
      for (int a = 0; a < DEPTH; a++) rd_op(a);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
         if (n == 200) reset_pulse();
      end
      for (int a = 0; a < DEPTH; a++) rd_op(a);

      idle();
      idle();
      @(negedge clk);
      #1 check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_8x8.md
RAM_8X8 -- requirements
Module: ram_8x8

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of words; address width is log2(DEPTH), 3 at default.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all storage and output registers.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 D  input  WIDTH  write data.
REQ-007 w  input  1  operation select: 1 = write, 0 = read; qualified by en.
REQ-008 addr  input  log2(DEPTH)  word address, 0..DEPTH-1.
REQ-009 en  input  1  enable; no operation when 0.
REQ-010 out  output  WIDTH  registered read data.

Function
REQ-011 Storage SHALL be DEPTH independent WIDTH-bit word registers, selected by a full address decoder (one-hot word select).
REQ-012 Write: at a rising clk edge with en=1 and w=1, the block SHALL load word[addr] with D; all other words are unchanged.
REQ-013 Write: out SHALL be unchanged in a write cycle (no write-through).
REQ-014 Read: at a rising clk edge with en=1 and w=0, the block SHALL load out with word[addr]; read latency is one clock edge.
REQ-015 Idle: with en=0, no word SHALL change and out SHALL hold its last value, regardless of w, addr and D.
REQ-016 Address, data and control inputs SHALL be sampled only at the clock edge; changes between edges have no effect.
REQ-017 Decoding SHALL use the addr value sampled at the same edge as D.
REQ-018 Decoding: a write SHALL never land in the address from the previous cycle.
REQ-019 Back-to-back: a read of an address in the cycle after it was written SHALL return the newly written data.
REQ-020 Consecutive cycles: writes or reads to different addresses in consecutive cycles SHALL each complete independently.
REQ-021 All DEPTH addresses SHALL be valid; no wrap-around or out-of-range case exists at power-of-two DEPTH.
REQ-022 Non-power-of-two DEPTH: writes to addr >= DEPTH SHALL be ignored.
REQ-023 Non-power-of-two DEPTH: reads from addr >= DEPTH SHALL return 0.

Reset
REQ-024 While rst_n=0, all words and out SHALL be cleared to 0 asynchronously, independent of clk.
REQ-025 Reset SHALL take priority over any simultaneous read or write.
REQ-026 After reset, an address never written SHALL read 0.
REQ-027 After rst_n deasserts, the first rising clk edge SHALL perform normal operation.
REQ-028 Reset asserted mid-operation SHALL abort that operation and clear all contents.

Verification
REQ-029 Power-up: assert rst_n=0, release it, then read addr 0..7 -> out=0x00 for every address.
REQ-030 Basic write/read:
- write 0x01 to addr 1, then idle a cycle;
- write 0x0B to addr 4;
- read addr 1 -> out=0x01 one edge later;
- read addr 4 -> out=0x0B;
- with en=0 afterwards, out holds 0x0B.
REQ-031 Gating:
- with en=0, w=1, addr 2, D=0xFF -> later read of addr 2 returns 0x00;
- a write cycle with en=1, w=1 leaves out unchanged.
REQ-032 Full sweep: write addr i with 0xA0+i for i=0..7, read back all -> each matches; then overwrite addr 7 with 0x5A -> reads 0x5A, others unchanged.
REQ-033 Back-to-back: write 0x3C to addr 5, read addr 5 on the next edge -> out=0x3C.
REQ-034 Reset mid-run: after the sweep, pulse rst_n low between clock edges -> out=0x00 immediately; all addresses read 0x00.
